// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access engine and the memory.
// Request uses valid/ready; each accepted request gets exactly one resp_valid pulse.
// Master holds request fields stable while valid and not ready.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_valid;
    logic                  data_req_ready;
    logic [ADDR_WIDTH-1:0] data_req_addr;
    logic                  data_req_wr;
    logic [3:0]            data_req_wstrb;
    logic [31:0]           data_req_wdata;
    logic                  data_resp_valid;
    logic [31:0]           data_resp_rdata;

    modport master (
        output data_req_valid,
        output data_req_addr,
        output data_req_wr,
        output data_req_wstrb,
        output data_req_wdata,
        input  data_req_ready,
        input  data_resp_valid,
        input  data_resp_rdata
    );

    modport slave (
        input  data_req_valid,
        input  data_req_addr,
        input  data_req_wr,
        input  data_req_wstrb,
        input  data_req_wdata,
        output data_req_ready,
        output data_resp_valid,
        output data_resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data access engine: strobes/replicated wdata, load extension, misalign traps.
// Latency: 4 cycles minimum (IDLE, REQ, WAIT, DONE), pipeline stalled for the first 3.
// Backpressure: request held stable until data_req_ready; flush withdraws or drains.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [2:0]  MEM_LoadType,
    input  logic [1:0]  MEM_StoreType,
    input  logic        MEM_Flush,
    output logic        mem_stall,
    output logic [31:0] mem_wb_data,
    output logic        except_adel,
    output logic        except_ades,
    output logic [31:0] bad_vaddr,
    mem_access_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LW  = 3'd5;
    localparam logic [1:0] ST_SB  = 2'd1;
    localparam logic [1:0] ST_SH  = 2'd2;
    localparam logic [1:0] ST_SW  = 2'd3;

    state_t state, state_nxt;

    logic                  is_load;
    logic                  is_store;
    logic                  misalign;
    logic                  start;
    logic [3:0]            st_wstrb;
    logic [31:0]           st_wdata;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_wstrb;
    logic                  lat_wr;
    logic [2:0]            lat_type;

    // Lane select from the latched byte offset, then extend per load type.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                             input logic [1:0]  off,
                                             input logic [2:0]  lt);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (lt)
            LT_LB:   fmt_load = {{24{sh[7]}}, sh[7:0]};
            LT_LBU:  fmt_load = {24'd0, sh[7:0]};
            LT_LH:   fmt_load = {{16{sh[15]}}, sh[15:0]};
            LT_LHU:  fmt_load = {16'd0, sh[15:0]};
            default: fmt_load = rd;
        endcase
    endfunction

    always_comb begin
        is_load  = (MEM_LoadType >= LT_LB) && (MEM_LoadType <= LT_LW);
        is_store = !is_load && (MEM_StoreType != 2'd0);
        misalign = 1'b0;
        if (is_load) begin
            if ((MEM_LoadType == LT_LH || MEM_LoadType == LT_LHU) && MEM_ALUOut[0])
                misalign = 1'b1;
            if (MEM_LoadType == LT_LW && MEM_ALUOut[1:0] != 2'b00)
                misalign = 1'b1;
        end else if (is_store) begin
            if (MEM_StoreType == ST_SH && MEM_ALUOut[0])
                misalign = 1'b1;
            if (MEM_StoreType == ST_SW && MEM_ALUOut[1:0] != 2'b00)
                misalign = 1'b1;
        end
        except_adel = is_load && misalign;
        except_ades = is_store && misalign;
        bad_vaddr   = (except_adel || except_ades) ? MEM_ALUOut : 32'd0;
        start       = (is_load || is_store) && !misalign && !MEM_Flush;
    end

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'd0;
        case (MEM_StoreType)
            ST_SB: begin
                st_wstrb = 4'b0001 << MEM_ALUOut[1:0];
                st_wdata = {4{MEM_OutB[7:0]}};
            end
            ST_SH: begin
                st_wstrb = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{MEM_OutB[15:0]}};
            end
            ST_SW: begin
                st_wstrb = 4'b1111;
                st_wdata = MEM_OutB;
            end
            default: begin
                st_wstrb = 4'b0000;
                st_wdata = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // An accepted request always owes one response; flush after acceptance must drain it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.data_req_ready)
                    state_nxt = MEM_Flush ? S_DRAIN : S_WAIT;
                else if (MEM_Flush)
                    state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (bus.data_resp_valid)
                    state_nxt = MEM_Flush ? S_IDLE : S_DONE;
                else if (MEM_Flush)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.data_resp_valid)
                    state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.data_req_valid = (state == S_REQ);
        bus.data_req_addr  = lat_addr;
        bus.data_req_wr    = lat_wr;
        bus.data_req_wstrb = lat_wstrb;
        bus.data_req_wdata = lat_wdata;
        case (state)
            S_IDLE:  mem_stall = start;
            S_REQ,
            S_WAIT,
            S_DRAIN: mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr    <= '0;
            lat_wdata   <= 32'd0;
            lat_wstrb   <= 4'b0000;
            lat_wr      <= 1'b0;
            lat_type    <= 3'd0;
            mem_wb_data <= 32'd0;
        end else begin
            if (state == S_IDLE && start) begin
                lat_addr  <= MEM_ALUOut[ADDR_WIDTH-1:0];
                lat_wr    <= is_store;
                lat_wstrb <= is_store ? st_wstrb : 4'b0000;
                lat_wdata <= is_store ? st_wdata : 32'd0;
                lat_type  <= is_load ? MEM_LoadType : 3'd0;
            end
            if (state == S_WAIT && bus.data_resp_valid && !MEM_Flush && !lat_wr)
                mem_wb_data <= fmt_load(bus.data_resp_rdata, lat_addr[1:0], lat_type);
        end
    end

endmodule
